// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, packet-aware arbiter sharing one FIFO write port.
// Define FIFO_WR_ARB_STAT_EN to add saturating per-requester beat counters.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          fifo_wr_ena,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic [IDW-1:0]                grant_id,
`ifdef FIFO_WR_ARB_STAT_EN
    input  logic                          stat_clr,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_beats,
`endif
    output logic                          busy
);
    localparam logic [0:0]   IDLE   = 1'b0;
    localparam logic [0:0]   LOCKED = 1'b1;
    localparam logic [IDW:0] NR     = (IDW+1)'(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 16 || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("fifo_wr_arb: unsupported NUM_REQ or CNT_WIDTH");
    end

    logic [0:0]         state;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] rot;
    logic [IDW:0]       off;
    logic [IDW:0]       sum;
    logic [IDW:0]       inc;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     nxt;
    logic               found;
    logic               has_sel;
    logic               xfer;
    logic               last;

    // rot[k] is the request of requester (rr_ptr + k) mod NUM_REQ
    assign rot = NUM_REQ'({req_vld, req_vld} >> rr_ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = (IDW+1)'(k);
            end
        end
    end

    assign sum     = {1'b0, rr_ptr} + off;
    assign sel     = (state == LOCKED) ? owner : IDW'((sum >= NR) ? sum - NR : sum);
    assign has_sel = (state == LOCKED) || found;
    assign req_rdy = (has_sel && !fifo_full) ? NUM_REQ'(1) << sel : '0;
    assign xfer    = |(req_rdy & req_vld);
    assign last    = |(req_rdy & req_vld & req_last);
    assign inc     = {1'b0, sel} + 1'b1;
    assign nxt     = (inc == NR) ? '0 : IDW'(inc);

    assign fifo_wr_ena = xfer;
    assign fifo_din    = has_sel ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign busy        = (state == LOCKED);

    // priority rotates per packet, so rr_ptr only moves on a last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (xfer) begin
            grant_id <= sel;
            if (state == IDLE && !last) begin
                state <= LOCKED;
                owner <= sel;
            end else if (state == LOCKED && last) begin
                state <= IDLE;
            end
            if (last) rr_ptr <= nxt;
        end
    end

`ifdef FIFO_WR_ARB_STAT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (stat_clr) cnt <= '0;
            else if (req_vld[i] && req_rdy[i] && cnt != '1) cnt <= cnt + 1'b1;
        end
        assign stat_beats[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed plus randomized checks of fifo_wr_arb against a packet-level model.
module tb_fifo_wr_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_rdy;
    logic            fifo_wr_ena;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_WR_ARB_STAT_EN
    logic            stat_clr = 1'b0;
    logic [N*CW-1:0] stat_beats;
`endif

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_vld(req_vld),
        .req_last(req_last),
        .req_data(req_data),
        .req_rdy(req_rdy),
        .fifo_wr_ena(fifo_wr_ena),
        .fifo_din(fifo_din),
        .fifo_full(fifo_full),
        .grant_id(grant_id),
`ifdef FIFO_WR_ARB_STAT_EN
        .stat_clr(stat_clr),
        .stat_beats(stat_beats),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_wr = 0;
    bit m_locked;
    int m_owner, m_ptr, m_gid;
    int m_cnt[N];
    bit e_has, e_x, e_last;
    int e_sel;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_gid    = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    // Predict this cycle's outputs from the packet-level rules and compare.
    task automatic compare();
        e_has = 0;
        e_sel = 0;
        if (m_locked) begin
            e_has = 1;
            e_sel = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!e_has && req_vld[i]) begin
                    e_has = 1;
                    e_sel = i;
                end
            end
        end
        e_x    = e_has && !fifo_full && req_vld[e_sel];
        e_last = req_last[e_sel];
        if (fifo_wr_ena) n_wr++;
        check("req_rdy", req_rdy, (e_has && !fifo_full) ? (64'd1 << e_sel) : 64'd0);
        check("wr_ena", fifo_wr_ena, e_x);
        check("din", fifo_din, e_has ? req_data[e_sel*DW +: DW] : 0);
        check("busy", busy, m_locked);
        check("grant_id", grant_id, m_gid);
`ifdef FIFO_WR_ARB_STAT_EN
        for (int i = 0; i < N; i++) check("stat", stat_beats[i*CW +: CW], m_cnt[i]);
`endif
    endtask

    function automatic void advance();
`ifdef FIFO_WR_ARB_STAT_EN
        if (stat_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        else if (e_x && m_cnt[e_sel] < (1 << CW) - 1) m_cnt[e_sel]++;
`endif
        if (e_x) begin
            m_gid = e_sel;
            if (!m_locked && !e_last) begin
                m_locked = 1;
                m_owner  = e_sel;
            end else if (m_locked && e_last) begin
                m_locked = 0;
            end
            if (e_last) m_ptr = (e_sel + 1) % N;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        req_vld   = v;
        req_last  = l;
        fifo_full = f;
        req_data  = $urandom;
        step();
    endtask

    task automatic do_reset();
        req_vld   = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_gid", grant_id, 0);
        check("rst_async_wr", fifo_wr_ena, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        model_reset();
        do_reset();
        drive('0, '0, 1'b0);
        check("rst_rdy", req_rdy, 0);
        check("rst_din", fifo_din, 0);

        for (int k = 0; k < 5; k++) begin
            drive('1, '1, 1'b0);
            check("rr_order", grant_id, k % 4);
        end

        do_reset();
        drive(4'b0010, 4'b0010, 1'b0);
        for (int b = 0; b < 3; b++) begin
            drive(4'b0111, (b == 2) ? 4'b0100 : 4'b0000, 1'b0);
            check("pkt_gid", grant_id, 2);
            check("pkt_busy", busy, b < 2);
        end
        drive(4'b0011, 4'b0011, 1'b0);
        check("pkt_next", grant_id, 0);

        do_reset();
        drive(4'b0010, 4'b0000, 1'b0);
        for (int b = 0; b < 2; b++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            check("bubble_wr", fifo_wr_ena, 0);
            check("bubble_busy", busy, 1);
        end
        drive(4'b0011, 4'b0010, 1'b0);
        check("bubble_gid", grant_id, 1);
        check("bubble_done", busy, 0);

        do_reset();
        base = n_wr;
        drive(4'b1000, 4'b0000, 1'b0);
        for (int b = 0; b < 3; b++) begin
            drive(4'b1001, 4'b0000, 1'b1);
            check("full_rdy", req_rdy, 0);
            check("full_wr", fifo_wr_ena, 0);
        end
        drive(4'b1001, 4'b0000, 1'b0);
        drive(4'b1001, 4'b1000, 1'b0);
        check("full_gid", grant_id, 3);
        check("full_beats", n_wr - base, 3);
        drive(4'b0100, 4'b0000, 1'b0);
        check("midpkt_busy", busy, 1);
        do_reset();

`ifdef FIFO_WR_ARB_STAT_EN
        for (int b = 0; b < 20; b++) drive(4'b1000, 4'b1000, 1'b0);
        check("stat_sat", stat_beats[3*CW +: CW], 15);
        stat_clr = 1'b1;
        drive(4'b1000, 4'b1000, 1'b0);
        stat_clr = 1'b0;
        check("stat_clr", stat_beats[3*CW +: CW], 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(499) == 0) do_reset();
`ifdef FIFO_WR_ARB_STAT_EN
            stat_clr = ($urandom_range(49) == 0);
`endif
            drive(N'($urandom), N'($urandom), $urandom_range(4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin, packet-aware arbiter sharing the single write port of an L1D `fifo` instance among `NUM_REQ` requesters, e.g. miss, writeback and snoop-response sources. It sits directly in front of the FIFO, sees only the FIFO's `full` flag and drives its `wr_ena`/`din`. Multi-beat packets are never interleaved: a requester keeps the port from its first accepted beat until its `last` beat is accepted.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16, need not be a power of two.
- `DATA_WIDTH`, 8: beat width; equals the FIFO's `DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of each statistics counter (see Configuration).
- `IDW`, derived, not overridable: max(1, $clog2(NUM_REQ)).

- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_vld` in NUM_REQ: requester i has a beat.
- `req_last` in NUM_REQ: requester i's beat is the final beat of its packet.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's data at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_rdy` out NUM_REQ: beat of requester i is accepted this cycle when `req_vld[i] && req_rdy[i]`.
- `fifo_wr_ena` out 1: to FIFO `wr_ena`.
- `fifo_din` out DATA_WIDTH: to FIFO `din`.
- `fifo_full` in 1: from FIFO `full`.
- `grant_id` out IDW: registered index of the last requester that transferred a beat.
- `busy` out 1: high while a packet is open (state LOCKED).

## Operation
- State: `state` ∈ {IDLE, LOCKED}, `owner` (IDW), `rr_ptr` (IDW), `grant_id` (IDW).
- Selection, combinational:
  - IDLE: `sel` is the first i with `req_vld[i]=1`, scanning rr_ptr, rr_ptr+1, … with wrap at NUM_REQ (not 2^IDW). If no `req_vld` is set, there is no selection.
  - LOCKED: `sel = owner` whether or not `req_vld[owner]` is set.
- `req_rdy[i] = (i == sel) && !fifo_full`; all zero when there is no selection.
- Transfer: `xfer = req_vld[sel] && req_rdy[sel]`. Then `fifo_wr_ena = xfer`.
- `fifo_din` is `req_data` of `sel` when there is a selection, otherwise all zeros.
- Transitions, all on a transfer:
  - IDLE, `req_last[sel]=0`: go to LOCKED and set `owner <= sel`.
  - IDLE, `req_last[sel]=1`: stay IDLE (single-beat packet).
  - LOCKED, `req_last[owner]=1`: go to IDLE.
  - LOCKED, `req_last[owner]=0`: stay LOCKED.
  - In every case, `grant_id <= sel`.
- `rr_ptr <= (sel+1) mod NUM_REQ` only when a transfer carries last. Priority rotates per packet, not per beat.
- The owner may drop `req_vld` between beats. Bubbles keep LOCKED, and other requesters wait.
- While `fifo_full=1`: all `req_rdy` are 0, no write happens, and all state holds.
- `req_last` is ignored on cycles without a transfer.
- With `NUM_REQ=1`: `rr_ptr`, `owner` and `grant_id` stay 0 permanently.

## Timing
- Zero-latency datapath: an accepted beat is written into the FIFO on the same posedge it is accepted.
- No combinational path from `fifo_wr_ena` back to `fifo_full`, so the loop is closed only through registers.
- Reset values: `state=IDLE`, `busy=0`, `owner=0`, `rr_ptr=0`, `grant_id=0`. With `req_vld=0` this gives `req_rdy=0`, `fifo_wr_ena=0`, `fifo_din=0`.
- Reset mid-packet: the state returns to IDLE asynchronously and the partial packet is abandoned. The system resets the FIFO on the same `rst_n`.
- `busy` and `grant_id` are registered and change one cycle after the transfer that causes them.
- Worst-case wait for a requester with a pending beat is NUM_REQ-1 complete packets.

## Configuration
- Macro: `FIFO_WR_ARB_STAT_EN`.
- Defined, the block adds these ports:
  - `stat_clr` in 1.
  - `stat_beats` out NUM_REQ*CNT_WIDTH, with counter i at `[i*CNT_WIDTH +: CNT_WIDTH]`.
- Counter behaviour when defined:
  - Counter i increments by 1 on each transfer from requester i and saturates at all-ones.
  - `stat_clr=1` clears all counters synchronously. Clear wins over a simultaneous increment.
  - Reset value is 0.
- Not defined: neither port exists, no counter flops are built, and arbitration behaviour is identical.

## Test plan
- Reset, then all `req_vld=0`: `req_rdy=0`, `fifo_wr_ena=0`, `fifo_din=0`, `busy=0`, `grant_id=0`.
- NUM_REQ=4, all four requesters issue single-beat packets (`last=1`) continuously with `fifo_full=0`: grant order is 0,1,2,3,0 and one write per cycle.
- Requester 2 sends a 3-beat packet while 0 and 1 hold `req_vld`:
  - Three consecutive writes come from requester 2 and `busy=1` during the packet.
  - Next grant goes to 3 if it is requesting, otherwise to 0.
- Requester 1 is LOCKED after beat 1, drops `req_vld` for 2 cycles while requester 0 requests: no writes occur, and requester 1's last beat is then accepted.
- `fifo_full=1` for 3 cycles in the middle of a packet: `req_rdy=0` and `fifo_wr_ena=0`; the packet then resumes with the same owner and no beat is lost or duplicated.
- With `FIFO_WR_ARB_STAT_EN` and `CNT_WIDTH=4`:
  - 20 beats from requester 3 leave `stat_beats[3]=15` (saturated).
  - Asserting `stat_clr` in a cycle where requester 3 also transfers gives 0.
